// File: rtl/mmio_timer_gpio_pkg.sv
// Shared register map, control/status bit positions and byte-lane merge helper
// for the MMIO timer/GPIO responder.
package mmio_timer_gpio_pkg;

  // Word offsets, i.e. addr[4:2]
  localparam logic [2:0] GPIO_OUT_OFS = 3'd0;
  localparam logic [2:0] GPIO_IN_OFS  = 3'd1;
  localparam logic [2:0] CTRL_OFS     = 3'd2;
  localparam logic [2:0] PRESCALE_OFS = 3'd3;
  localparam logic [2:0] COUNT_OFS    = 3'd4;
  localparam logic [2:0] CMP_OFS      = 3'd5;
  localparam logic [2:0] STATUS_OFS   = 3'd6;

  localparam int EN_BIT         = 0;
  localparam int AUTORELOAD_BIT = 1;
  localparam int IRQ_EN_BIT     = 2;
  localparam int MATCH_BIT      = 0;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mmio_timer_gpio_timer_core.sv
// Prescaled 32-bit up-counter with compare, MATCH flag and level interrupt.
// Register writes arrive as per-register enables plus the shared byte mask.
module timer_core
  import mmio_timer_gpio_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  input  logic        ctrl_we,
  input  logic        prescale_we,
  input  logic        count_we,
  input  logic        cmp_we,
  input  logic        status_w1c,
  output logic [2:0]  ctrl,
  output logic [15:0] prescale,
  output logic [31:0] count,
  output logic [31:0] cmp,
  output logic        match,
  output logic        irq
);

  logic [2:0]  ctrl_q, ctrl_d;
  logic [15:0] prescale_q, prescale_d, pcnt_q, pcnt_d;
  logic [31:0] count_q, count_d, cmp_q, cmp_d;
  logic        match_q, match_d;
  logic        tick, hit;
  logic [31:0] ctrl_m, prescale_m, count_m, cmp_m;
  logic        unused;

  always_comb begin
    tick = ctrl_q[EN_BIT] && (pcnt_q == prescale_q);
    hit  = tick && (count_q == cmp_q);

    ctrl_m     = byte_merge({29'b0, ctrl_q}, wdata, be);
    prescale_m = byte_merge({16'b0, prescale_q}, wdata, be);
    count_m    = byte_merge(count_q, wdata, be);
    cmp_m      = byte_merge(cmp_q, wdata, be);

    ctrl_d     = ctrl_we     ? ctrl_m[2:0]      : ctrl_q;
    prescale_d = prescale_we ? prescale_m[15:0] : prescale_q;
    cmp_d      = cmp_we      ? cmp_m            : cmp_q;

    if (ctrl_we || prescale_we || !ctrl_q[EN_BIT] || tick) pcnt_d = '0;
    else                                                   pcnt_d = pcnt_q + 16'd1;

    // A software write replaces the tick result; unwritten bytes keep the old value
    count_d = count_q;
    if (tick) count_d = (hit && ctrl_q[AUTORELOAD_BIT]) ? '0 : count_q + 32'd1;
    if (count_we) count_d = count_m;

    match_d = match_q;
    if (status_w1c && be[0] && wdata[MATCH_BIT]) match_d = 1'b0;
    if (hit) match_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      count_q    <= '0;
      cmp_q      <= '0;
      match_q    <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      count_q    <= count_d;
      cmp_q      <= cmp_d;
      match_q    <= match_d;
    end
  end

  assign unused   = ^{ctrl_m[31:3], prescale_m[31:16]};
  assign ctrl     = ctrl_q;
  assign prescale = prescale_q;
  assign count    = count_q;
  assign cmp      = cmp_q;
  assign match    = match_q;
  assign irq      = match_q & ctrl_q[IRQ_EN_BIT];

endmodule

// File: rtl/mmio_timer_gpio.sv
// Data-memory-side responder: window decode, GPIO registers with a two-flop
// input synchronizer, combinational read mux, and the timer core.
module mmio_timer_gpio
  import mmio_timer_gpio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          GPIO_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic [31:0]       data_wr,
  input  logic [3:0]        mask,
  input  logic              MemWrite,
  input  logic              MemRead,
  output logic [31:0]       data_rd,
  output logic              sel,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq
);

  logic [2:0]        ofs;
  logic              wr;
  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d, sync1_q, sync2_q;
  logic [31:0]       gpio_out_ext, gpio_in_ext, gpio_out_m;
  logic [2:0]        ctrl;
  logic [15:0]       prescale;
  logic [31:0]       count, cmp;
  logic              match;
  logic              unused;

  assign sel = (addr[31:5] == BASE_ADDR[31:5]);
  assign ofs = addr[4:2];
  // An all-zero mask changes nothing, including the prescaler clear on CTRL/PRESCALE
  assign wr  = MemWrite & sel & (|mask);

  always_comb begin
    gpio_out_ext               = '0;
    gpio_out_ext[GPIO_W-1:0]   = gpio_out_q;
    gpio_in_ext                = '0;
    gpio_in_ext[GPIO_W-1:0]    = sync2_q;
    gpio_out_m                 = byte_merge(gpio_out_ext, data_wr, mask);
    gpio_out_d = (wr && ofs == GPIO_OUT_OFS) ? gpio_out_m[GPIO_W-1:0] : gpio_out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
    end
  end

  timer_core u_timer (
    .clk         (clk),
    .rst         (rst),
    .wdata       (data_wr),
    .be          (mask),
    .ctrl_we     (wr && ofs == CTRL_OFS),
    .prescale_we (wr && ofs == PRESCALE_OFS),
    .count_we    (wr && ofs == COUNT_OFS),
    .cmp_we      (wr && ofs == CMP_OFS),
    .status_w1c  (wr && ofs == STATUS_OFS),
    .ctrl        (ctrl),
    .prescale    (prescale),
    .count       (count),
    .cmp         (cmp),
    .match       (match),
    .irq         (irq)
  );

  always_comb begin
    data_rd = '0;
    if (MemRead && sel) begin
      case (ofs)
        GPIO_OUT_OFS: data_rd = gpio_out_ext;
        GPIO_IN_OFS:  data_rd = gpio_in_ext;
        CTRL_OFS:     data_rd = {29'b0, ctrl};
        PRESCALE_OFS: data_rd = {16'b0, prescale};
        COUNT_OFS:    data_rd = count;
        CMP_OFS:      data_rd = cmp;
        STATUS_OFS:   data_rd = {31'b0, match};
        default:      data_rd = '0;
      endcase
    end
  end

  assign unused   = ^{addr[1:0], gpio_out_m};
  assign gpio_out = gpio_out_q;

endmodule

// File: tb/tb_mmio_timer_gpio.sv
// Directed bench: expected read words are queued when a read is driven and
// popped when data_rd is sampled; other outputs are checked directly.
module tb_mmio_timer_gpio;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0, data_wr = '0;
  logic [3:0]  mask = '0;
  logic        MemWrite = 1'b0, MemRead = 1'b0;
  logic [31:0] data_rd;
  logic        sel;
  logic [15:0] gpio_in = '0, gpio_out;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  mmio_timer_gpio #(.BASE_ADDR(BASE), .GPIO_W(16)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_wr(data_wr), .mask(mask),
    .MemWrite(MemWrite), .MemRead(MemRead), .data_rd(data_rd), .sel(sel),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] ofs, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    addr = BASE + {27'b0, ofs}; data_wr = d; mask = m; MemWrite = 1'b1; MemRead = 1'b0;
    @(posedge clk);
    #1;
    MemWrite = 1'b0; mask = '0; data_wr = '0;
  endtask

  task automatic rd_abs(input logic [31:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    exp_q.push_back(exp);
    addr = a; MemRead = 1'b1;
    #1;
    e = exp_q.pop_front();
    n_tests++;
    assert (data_rd === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, data_rd, e);
    end
    MemRead = 1'b0;
  endtask

  task automatic rd(input logic [4:0] ofs, input logic [31:0] exp, input string tag);
    rd_abs(BASE + {27'b0, ofs}, exp, tag);
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    chk("rst_gpio_out", {16'b0, gpio_out}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_data_rd_idle", data_rd, 32'h0);
    rd(5'h10, 32'h0, "rst_count");

    // GPIO_OUT byte lanes
    wr(5'h00, 32'h0000_A5A5, 4'b0001);
    chk("gpio_lane0", {16'b0, gpio_out}, 32'h0000_00A5);
    wr(5'h00, 32'h0000_A5A5, 4'b0010);
    chk("gpio_lane1", {16'b0, gpio_out}, 32'h0000_A5A5);
    wr(5'h00, 32'h0000_FFFF, 4'b0000);
    rd(5'h00, 32'h0000_A5A5, "gpio_mask0");
    wr(5'h00, 32'hFFFF_5A5A, 4'b1111);
    rd(5'h00, 32'h0000_5A5A, "gpio_upper_zero");

    // GPIO_IN synchronizer latency
    gpio_in = 16'h1234;
    rd(5'h04, 32'h0, "gpio_in_c1");
    step(1);
    rd(5'h04, 32'h0, "gpio_in_c2");
    step(1);
    rd(5'h04, 32'h0000_1234, "gpio_in_c3");
    chk("sel_in_window", {31'b0, sel}, 32'h1);
    rd(5'h1C, 32'h0, "reserved_rd");
    rd_abs(BASE + 32'h20, 32'h0, "outside_rd");
    chk("sel_outside", {31'b0, sel}, 32'h0);

    // PRESCALE=0, CMP=3, autoreload with irq
    wr(5'h0C, 32'h0, 4'b0011);
    wr(5'h14, 32'h3, 4'b1111);
    wr(5'h08, 32'h7, 4'b0001);
    rd(5'h10, 32'h0, "ar_count0");
    for (int i = 1; i <= 3; i++) begin
      step(1);
      rd(5'h10, i, "ar_count_up");
      chk("ar_irq_low", {31'b0, irq}, 32'h0);
    end
    step(1);
    rd(5'h10, 32'h0, "ar_reload");
    chk("ar_irq_high", {31'b0, irq}, 32'h1);
    rd(5'h18, 32'h1, "ar_match");
    step(1);
    rd(5'h10, 32'h1, "ar_count_after");
    chk("ar_irq_hold", {31'b0, irq}, 32'h1);
    wr(5'h18, 32'h1, 4'b0001);
    chk("w1c_irq", {31'b0, irq}, 32'h0);
    rd(5'h10, 32'h2, "w1c_count");
    wr(5'h08, 32'h0, 4'b0001);
    rd(5'h10, 32'h3, "stop_count");

    // PRESCALE=2, CMP=1, no autoreload
    wr(5'h10, 32'h0, 4'b1111);
    wr(5'h0C, 32'h2, 4'b0011);
    wr(5'h14, 32'h1, 4'b1111);
    wr(5'h08, 32'h5, 4'b0001);
    rd(5'h10, 32'h0, "ps_e0");
    step(2);
    rd(5'h10, 32'h0, "ps_e2");
    step(1);
    rd(5'h10, 32'h1, "ps_e3");
    step(2);
    rd(5'h10, 32'h1, "ps_e5");
    chk("ps_irq_low", {31'b0, irq}, 32'h0);
    step(1);
    rd(5'h10, 32'h2, "ps_e6");
    chk("ps_irq_high", {31'b0, irq}, 32'h1);
    step(3);
    rd(5'h10, 32'h3, "ps_e9");

    // Wrap and write-vs-tick collisions
    wr(5'h08, 32'h0, 4'b0001);
    wr(5'h18, 32'h1, 4'b0001);
    wr(5'h0C, 32'h0, 4'b0011);
    wr(5'h10, 32'hFFFF_FFFF, 4'b1111);
    wr(5'h08, 32'h5, 4'b0001);
    rd(5'h10, 32'hFFFF_FFFF, "wrap_pre");
    step(1);
    rd(5'h10, 32'h0, "wrap_zero");
    wr(5'h10, 32'h10, 4'b1111);
    rd(5'h10, 32'h10, "write_wins");
    step(1);
    rd(5'h10, 32'h11, "after_write");
    wr(5'h10, 32'h0000_01FF, 4'b1111);
    wr(5'h10, 32'h0000_5500, 4'b0010);
    rd(5'h10, 32'h0000_55FF, "partial_write");

    // Reset with MATCH=1 while counting
    wr(5'h14, 32'h0000_5601, 4'b1111);
    step(2);
    chk("pre_rst_irq", {31'b0, irq}, 32'h1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("post_rst_irq", {31'b0, irq}, 32'h0);
    chk("post_rst_gpio", {16'b0, gpio_out}, 32'h0);
    rd(5'h08, 32'h0, "post_rst_ctrl");
    rd(5'h14, 32'h0, "post_rst_cmp");
    rd(5'h18, 32'h0, "post_rst_status");
    step(3);
    rd(5'h10, 32'h0, "post_rst_stopped");
    wr(5'h08, 32'h1, 4'b0001);
    step(2);
    rd(5'h10, 32'h2, "restart_count");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
